// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//    Consumer end of the rPLL clock path. Lives in the PLL output clock domain,
//    synchronises the PLL LOCK output, waits until lock has been stable for
//    STABLE_CYCLES consecutive cycles, then releases the core reset, waits a
//    further PERIPH_DELAY cycles and releases the peripheral reset. Any loss of
//    lock or a software request re-runs the sequence. Lock loss while fully
//    running is reported with a one-cycle pulse.
//
// Parameters:
//    SYNC_STAGES    lock synchroniser depth (2..4)
//    STABLE_CYCLES  consecutive synchronised-lock cycles before core release
//                   (1..65535)
//    PERIPH_DELAY   cycles between core release and peripheral release (1..255)
//
// Ports:
//    clk            PLL output clock, rising edge
//    rst            synchronous active-high reset
//    lock_i         PLL LOCK, asynchronous to clk
//    soft_rst_req   single-cycle request to re-run the sequence
//    rst_core       active-high reset to core logic
//    rst_periph     active-high reset to peripherals
//    ready          both resets released
//    lock_lost      one-cycle pulse when synchronised lock falls while ready
//    lock_lost_cnt  saturating count of lock_lost pulses
//
// Configuration macro:
//    PLL_LOCK_LOSS_COUNT_EN  when defined, lock_lost_cnt counts lock_lost
//                            pulses and saturates at 255 (cleared by rst only).
//                            When undefined, lock_lost_cnt is tied to 0 and no
//                            counter flops exist.
//
// Handshake / timing note:
//    There is no valid/ready handshake here; soft_rst_req is a level sampled
//    every cycle and is treated as a one-cycle pulse. Every output is a flop
//    loaded from the next-state decision, so a transition decided in cycle N
//    is visible on the outputs in cycle N+1.
//
// Debug visibility:
//    state_q holds the FSM state (WAIT_LOCK/STABLE/CORE_UP/RUN) and is the
//    signal to probe when binding checkers.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned PERIPH_DELAY  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lock_i,
   input  logic       soft_rst_req,
   output logic       rst_core,
   output logic       rst_periph,
   output logic       ready,
   output logic       lock_lost,
   output logic [7:0] lock_lost_cnt
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      CORE_UP   = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Terminal counts; both counters stop at these values rather than wrap.
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [7:0]  DELAY_LAST  = 8'(PERIPH_DELAY - 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [15:0]            stable_cnt_q, stable_cnt_d;
   logic [7:0]             delay_cnt_q, delay_cnt_d;
   logic                   rst_core_q, rst_core_d;
   logic                   rst_periph_q, rst_periph_d;
   logic                   ready_q, ready_d;
   logic                   lock_lost_q, lock_lost_d;
   logic                   lock_s;

   // Synchroniser: lock_i enters at bit 0 and reaches the top bit after
   // SYNC_STAGES edges.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], lock_i};
   assign lock_s = sync_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // State register (plus synchroniser, counters and registered outputs)
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_LOCK;
         sync_q       <= '0;
         stable_cnt_q <= '0;
         delay_cnt_q  <= '0;
         rst_core_q   <= 1'b1;
         rst_periph_q <= 1'b1;
         ready_q      <= 1'b0;
         lock_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         stable_cnt_q <= stable_cnt_d;
         delay_cnt_q  <= delay_cnt_d;
         rst_core_q   <= rst_core_d;
         rst_periph_q <= rst_periph_d;
         ready_q      <= ready_d;
         lock_lost_q  <= lock_lost_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // Priority in every active state: lock drop, then soft request, then
   // normal progress. A soft request restarts at STABLE with a cleared
   // counter so the whole stability window is re-run.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      delay_cnt_d  = delay_cnt_q;

      case (state_q)
         WAIT_LOCK: begin
            stable_cnt_d = '0;
            delay_cnt_d  = '0;
            if (lock_s) begin
               state_d = STABLE;
            end
         end

         STABLE: begin
            delay_cnt_d = '0;
            if (!lock_s) begin
               state_d      = WAIT_LOCK;
               stable_cnt_d = '0;
            end else if (soft_rst_req) begin
               state_d      = STABLE;
               stable_cnt_d = '0;
            end else if (stable_cnt_q == STABLE_LAST) begin
               state_d = CORE_UP;
            end else begin
               stable_cnt_d = stable_cnt_q + 16'd1;
            end
         end

         CORE_UP: begin
            if (!lock_s) begin
               state_d      = WAIT_LOCK;
               stable_cnt_d = '0;
               delay_cnt_d  = '0;
            end else if (soft_rst_req) begin
               state_d      = STABLE;
               stable_cnt_d = '0;
               delay_cnt_d  = '0;
            end else if (delay_cnt_q == DELAY_LAST) begin
               state_d = RUN;
            end else begin
               delay_cnt_d = delay_cnt_q + 8'd1;
            end
         end

         RUN: begin
            if (!lock_s) begin
               state_d      = WAIT_LOCK;
               stable_cnt_d = '0;
               delay_cnt_d  = '0;
            end else if (soft_rst_req) begin
               state_d      = STABLE;
               stable_cnt_d = '0;
               delay_cnt_d  = '0;
            end
         end

         default: begin
            state_d      = WAIT_LOCK;
            stable_cnt_d = '0;
            delay_cnt_d  = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output logic
   // Decoded from the next state so the registered outputs change together
   // with state_q. lock_lost looks at the current state: only a drop out of
   // RUN is reported.
   // --------------------------------------------------------------------------
   always_comb begin
      rst_core_d   = 1'b1;
      rst_periph_d = 1'b1;
      ready_d      = 1'b0;
      lock_lost_d  = 1'b0;

      case (state_d)
         CORE_UP: begin
            rst_core_d = 1'b0;
         end
         RUN: begin
            rst_core_d   = 1'b0;
            rst_periph_d = 1'b0;
            ready_d      = 1'b1;
         end
         default: begin
            rst_core_d   = 1'b1;
            rst_periph_d = 1'b1;
         end
      endcase

      if ((state_q == RUN) && !lock_s) begin
         lock_lost_d = 1'b1;
      end
   end

`ifdef PLL_LOCK_LOSS_COUNT_EN
   // Saturating event counter; soft requests never touch it.
   logic [7:0] lost_cnt_q, lost_cnt_d;

   always_comb begin
      lost_cnt_d = lost_cnt_q;
      if (lock_lost_d && (lost_cnt_q != 8'hFF)) begin
         lost_cnt_d = lost_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lost_cnt_q <= '0;
      end else begin
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign lock_lost_cnt = lost_cnt_q;
`else
   assign lock_lost_cnt = 8'd0;
`endif

   assign rst_core   = rst_core_q;
   assign rst_periph = rst_periph_q;
   assign ready      = ready_q;
   assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2, STABLE_CYCLES=8,
// PERIPH_DELAY=4. A reference model tracks, at the level of "how many
// consecutive cycles has synchronised lock been credited", what every output
// must be; a compare process checks all outputs every cycle. The directed
// sequence also pins key delays with hand-computed literals.
// Build with +define+PLL_LOCK_LOSS_COUNT_EN to cover the event counter.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int S  = 2;
  localparam int SC = 8;
  localparam int PD = 4;

  // Credited-lock streak thresholds: core out of reset once the streak
  // reaches SC+1 (one cycle is spent noticing lock), peripherals after PD more.
  localparam int CORE_N = SC + 1;
  localparam int RUN_N  = SC + 1 + PD;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       rst;
  logic       lock_i;
  logic       soft_rst_req;
  logic       rst_core;
  logic       rst_periph;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_lost_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES   (S),
    .STABLE_CYCLES (SC),
    .PERIPH_DELAY  (PD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lock_i        (lock_i),
    .soft_rst_req  (soft_rst_req),
    .rst_core      (rst_core),
    .rst_periph    (rst_periph),
    .ready         (ready),
    .lock_lost     (lock_lost),
    .lock_lost_cnt (lock_lost_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (updated at each rising edge from the sampled inputs)
  // ---------------------------------------------------------------------------
  logic       m_sync [S];
  int         m_streak;
  logic       m_valid = 1'b0;
  logic       e_lost;
  logic [7:0] e_cnt;
  logic [7:0] exp_q [$];   // expected lock_lost_cnt history, one per cycle

  always @(posedge clk) begin
    logic ls;
    if (rst) begin
      for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
      m_streak = 0;
      e_lost   = 1'b0;
      e_cnt    = 8'd0;
    end else begin
      ls     = m_sync[S-1];
      e_lost = !ls && (m_streak >= RUN_N);
      if (e_lost && CNT_ON == 1 && e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
      if (!ls)                                m_streak = 0;
      else if (soft_rst_req && m_streak > 0)  m_streak = 1;
      else if (m_streak < 1000000)            m_streak = m_streak + 1;
      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = lock_i;
    end
    exp_q.push_back(e_cnt);
    m_valid = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare process: every cycle, on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [7:0] ec;
    if (m_valid && exp_q.size() > 0) begin
      ec = exp_q.pop_front();
      check("sb_rst_core",   {31'd0, rst_core},   {31'd0, (m_streak < CORE_N)});
      check("sb_rst_periph", {31'd0, rst_periph}, {31'd0, (m_streak < RUN_N)});
      check("sb_ready",      {31'd0, ready},      {31'd0, (m_streak >= RUN_N)});
      check("sb_lock_lost",  {31'd0, lock_lost},  {31'd0, e_lost});
      check("sb_lost_cnt",   {24'd0, lock_lost_cnt}, {24'd0, ec});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until the selected output reaches val.
  // which: 0=rst_core 1=rst_periph 2=ready
  task automatic wait_for(input int which, input logic val, input int bound, output int k);
    logic done;
    k    = 0;
    done = 1'b0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
      case (which)
        0:       done = (rst_core == val);
        1:       done = (rst_periph == val);
        default: done = (ready == val);
      endcase
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: output %0d never reached %0d within %0d cycles", which, val, bound);
    end
  endtask

  task automatic pulse_soft();
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    rst          = 1'b1;
    lock_i       = 1'b0;
    soft_rst_req = 1'b0;
    cycles(3);

    // Reset values
    check("rst_core_reset",   {31'd0, rst_core},   32'd1);
    check("rst_periph_reset", {31'd0, rst_periph}, 32'd1);
    check("ready_reset",      {31'd0, ready},      32'd0);
    check("lost_reset",       {31'd0, lock_lost},  32'd0);
    check("cnt_reset",        {24'd0, lock_lost_cnt}, 32'd0);

    // 1. Clean lock rise; a soft request while waiting for lock is ignored.
    rst = 1'b0;
    cycles(3);
    pulse_soft();
    cycles(2);
    lock_i = 1'b1;
    wait_for(0, 1'b0, 200, k);
    check("t1_core_delay", k, 32'd11);
    wait_for(1, 1'b0, 200, k);
    check("t1_periph_delay", k, 32'd4);
    check("t1_ready", {31'd0, ready}, 32'd1);

    // 2. One-cycle lock glitch inside the stability window: full restart.
    lock_i = 1'b0;
    rst    = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(3);
    lock_i = 1'b1;
    cycles(5);
    lock_i = 1'b0;
    cycles(1);
    lock_i = 1'b1;
    wait_for(0, 1'b0, 200, k);
    check("t2_core_after_reraise", k, 32'd11);
    wait_for(2, 1'b1, 200, k);

    // 3. Lock drop in RUN
    cycles(2);
    lock_i = 1'b0;
    cycles(2);
    check("t3_core_still_low", {31'd0, rst_core}, 32'd0);
    check("t3_ready_still_hi", {31'd0, ready},    32'd1);
    cycles(1);
    check("t3_core_reassert",   {31'd0, rst_core},   32'd1);
    check("t3_periph_reassert", {31'd0, rst_periph}, 32'd1);
    check("t3_ready_drop",      {31'd0, ready},      32'd0);
    check("t3_lost_pulse",      {31'd0, lock_lost},  32'd1);
    check("t3_cnt_one",         {24'd0, lock_lost_cnt}, (CNT_ON == 1) ? 32'd1 : 32'd0);
    cycles(1);
    check("t3_lost_one_cycle",  {31'd0, lock_lost},  32'd0);

    // 4. Soft request in RUN with steady lock
    lock_i = 1'b1;
    wait_for(2, 1'b1, 200, k);
    cycles(3);
    pulse_soft();
    check("t4_core_reassert", {31'd0, rst_core},  32'd1);
    check("t4_ready_drop",    {31'd0, ready},     32'd0);
    check("t4_no_lost",       {31'd0, lock_lost}, 32'd0);
    wait_for(0, 1'b0, 200, k);
    check("t4_core_delay", k, 32'd8);
    check("t4_cnt_same", {24'd0, lock_lost_cnt}, (CNT_ON == 1) ? 32'd1 : 32'd0);
    wait_for(2, 1'b1, 200, k);

    // Soft request during the stability window restarts it.
    lock_i = 1'b0;
    cycles(4);
    lock_i = 1'b1;
    cycles(6);
    pulse_soft();
    wait_for(0, 1'b0, 200, k);
    check("t4b_core_after_soft", k, 32'd8);
    wait_for(2, 1'b1, 200, k);

    // 5. Many lock-loss events: counter saturates
    for (int i = 0; i < 300; i++) begin
      lock_i = 1'b0;
      cycles(4);
      lock_i = 1'b1;
      wait_for(2, 1'b1, 100, k);
    end
    check("t5_cnt_sat", {24'd0, lock_lost_cnt}, (CNT_ON == 1) ? 32'd255 : 32'd0);
    lock_i = 1'b0;
    cycles(4);
    check("t5_cnt_hold", {24'd0, lock_lost_cnt}, (CNT_ON == 1) ? 32'd255 : 32'd0);
    rst = 1'b1;
    cycles(1);
    check("t5_cnt_cleared", {24'd0, lock_lost_cnt}, 32'd0);

    // 6. rst during CORE_UP, lock held high throughout
    lock_i = 1'b1;
    rst    = 1'b0;
    wait_for(0, 1'b0, 200, k);
    check("t6_first_core", k, 32'd11);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    check("t6_core_reassert",   {31'd0, rst_core},   32'd1);
    check("t6_periph_reassert", {31'd0, rst_periph}, 32'd1);
    check("t6_ready_low",       {31'd0, ready},      32'd0);
    rst = 1'b0;
    wait_for(0, 1'b0, 200, k);
    check("t6_core_repeat", k, 32'd11);
    wait_for(1, 1'b0, 200, k);
    check("t6_periph_repeat", k, 32'd4);
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Consumer end of the rPLL clock-generation path. Runs in the PLL output clock domain and takes the PLL's asynchronous LOCK output. Qualifies lock stability and then releases staged, synchronous active-high resets to the CV core logic and its peripherals, in that order. Re-sequences on any loss of lock or on a software reset request, and reports lock-loss events.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the lock synchronizer (legal 2..4)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before the core reset is released (legal 1..65535)
PERIPH_DELAY, 16, cycles between core reset release and peripheral reset release (legal 1..255)

Ports:
clk  input  1  PLL output clock; all logic on its rising edge
rst  input  1  synchronous active-high reset
lock_i  input  1  PLL LOCK, asynchronous to clk
soft_rst_req  input  1  single-cycle request to re-run the sequence; synchronous to clk
rst_core  output  1  active-high reset to core logic
rst_periph  output  1  active-high reset to peripherals
ready  output  1  high when both resets are released
lock_lost  output  1  one-cycle pulse when synchronized lock falls while ready=1
lock_lost_cnt  output  8  count of lock_lost events (see Optional Feature)

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values while rst=1:
  - state=WAIT_LOCK
  - rst_core=1, rst_periph=1, ready=0, lock_lost=0, lock_lost_cnt=0
  - all synchronizer flops=0, stable counter=0
- lock_i passes through a SYNC_STAGES-flop synchronizer, giving lock_s. lock_i rising appears on lock_s SYNC_STAGES cycles later.
- States:
  - WAIT_LOCK: rst_core=1, rst_periph=1. Stable counter is held at 0. Go to STABLE when lock_s=1.
  - STABLE: counter increments each cycle lock_s=1. lock_s=0 returns to WAIT_LOCK and clears the counter. When the counter reaches STABLE_CYCLES-1 with lock_s=1, go to CORE_UP.
  - CORE_UP: rst_core=0, rst_periph=1. A delay counter runs for PERIPH_DELAY cycles, then go to RUN.
  - RUN: rst_core=0, rst_periph=0, ready=1.
- Timing for a clean lock rise: rst_core deasserts exactly SYNC_STAGES+STABLE_CYCLES+1 cycles after lock_i rises at a clock edge. rst_periph deasserts exactly PERIPH_DELAY cycles after rst_core.
- All outputs are registered. A state change is visible on outputs in the cycle after the transition decision.
- Lock drop (lock_s=0) in CORE_UP or RUN:
  - Next state is WAIT_LOCK.
  - rst_core and rst_periph both reassert on the next cycle.
  - ready drops on the same cycle.
  - lock_lost pulses for one cycle, only if the state was RUN.
- soft_rst_req=1 in any state except WAIT_LOCK: next state is STABLE with the counter cleared (the full stability window is re-run). Both resets reassert on the next cycle. lock_lost does not pulse.
- Simultaneous soft_rst_req and lock drop: the lock drop wins (WAIT_LOCK). lock_lost pulses if the state was RUN.
- rst mid-sequence: returns immediately to reset values. The stable window restarts from zero.
- Glitch of lock_s low for one cycle during STABLE: full restart. There is no partial credit.
- Counter widths: the stable counter is 16 bits and the delay counter is 8 bits. Neither counter wraps; each is compared against parameter-1 and stops there.

Optional Feature:
Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined: lock_lost_cnt increments on every lock_lost pulse and saturates at 255 (no wrap). It is cleared only by rst; soft_rst_req does not clear it.
- Not defined: lock_lost_cnt is a constant 0 and no counter flops are synthesized. lock_lost still pulses.

Test Plan:
1. STABLE_CYCLES=8, PERIPH_DELAY=4, SYNC_STAGES=2; release rst, raise lock_i at cycle 10 -> rst_core falls at cycle 21, rst_periph falls and ready rises at cycle 25, lock_lost never pulses.
2. Same config, lock_i low for exactly 1 cycle at cycle 15 (inside the stable window) -> counter restarts; rst_core falls 11 cycles after lock_i re-rises.
3. In RUN, drop lock_i -> SYNC_STAGES cycles later lock_s=0; the next cycle has rst_core=1, rst_periph=1, ready=0 and a one-cycle lock_lost pulse. With PLL_LOCK_LOSS_COUNT_EN, lock_lost_cnt goes 0->1.
4. In RUN with lock steady, pulse soft_rst_req -> resets reassert next cycle, no lock_lost pulse; rst_core falls again after 8 stable cycles; lock_lost_cnt unchanged.
5. With PLL_LOCK_LOSS_COUNT_EN, force 300 lock-loss events from RUN -> lock_lost_cnt=255 and holds; assert rst -> 0.
6. Assert rst during CORE_UP (rst_core=0) -> next cycle rst_core=1, rst_periph=1, ready=0. With lock_i held high, the full SYNC_STAGES+STABLE_CYCLES+1 sequence repeats after rst releases.
